// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and frame-length helper for the parametrised UART transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Total clocks occupied by one frame on the wire.
  function automatic int frame_len(input int cpb, input int dbits, input int par, input int stop);
    return cpb * (1 + dbits + ((par != PARITY_NONE) ? 1 : 0) + stop);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with show-ahead head word; a push at full is refused even alongside a pop.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words serialised as start/data/parity/stop frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  tx_state_e            state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;
  logic                 pop;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign in_ready  = !fifo_full && !rst;
  assign bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
  assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));
  // Pop either from idle or exactly at the end of the last stop bit, giving gapless frames.
  assign pop = tx_en && !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end && last_stop));

  assign tx   = tx_q;
  assign busy = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      baud_q <= (state_q == ST_IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);
      if (pop) begin
        shift_q  <= fifo_rdata;
        parity_q <= (^fifo_rdata) ^ (PARITY == PARITY_ODD);
        tx_q     <= 1'b0;
        busy_q   <= 1'b1;
        bit_q    <= '0;
        state_q  <= ST_START;
      end else begin
        case (state_q)
          ST_START: if (bit_end) begin
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
          ST_DATA: if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (last_data) begin
              bit_q <= '0;
              if (PARITY != PARITY_NONE) begin
                tx_q    <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              tx_q  <= shift_q[1];
            end
          end
          ST_PARITY: if (bit_end) begin
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
          ST_STOP: if (bit_end) begin
            if (last_stop) begin
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
          default: begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
